cp0_timer_unit: RTL
===================

CP0_TIMER_UNIT -- requirements
Module: cp0_timer_unit

Interface
REQ-001 SHALL have parameter NUM_HW_INT, default 6, number of live hardware interrupt lines (1..6); lines above it read as 0.
REQ-002 SHALL have parameter NUM_TIMERS, default 1, number of compare channels (1..4).
REQ-003 SHALL have parameter COUNT_DIV, default 1, clock cycles per Count increment (1..256).
REQ-004 SHALL have parameter PRID_VALUE, default 32'h004C0102, PRId read value.
REQ-005 SHALL have ports: clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: we_i  in  1  WB-stage mtc0 write enable; waddr_i  in  5  write address; data_i  in  32  write data.
REQ-007 SHALL have ports: raddr_i  in  5  read address; data_o  out  32  combinational read data.
REQ-008 SHALL have ports: int_i  in  6  hardware interrupt lines; exc_valid_i  in  1  exception commit; exc_code_i  in  5  ExcCode; exc_pc_i  in  32  faulting PC; exc_bd_i  in  1  faulting instruction in delay slot; eret_i  in  1  eret commit.
REQ-009 SHALL have ports: count_o, compare_o (channel 0), status_o, cause_o, epc_o, config_o, prid_o  out  32 each; timer_int_o  out  NUM_TIMERS  per-channel timer interrupt; int_pending_o  out  1  interrupt to be taken.

Function
REQ-010 SHALL map Count=9, Compare0=11, Status=12, Cause=13, EPC=14, PRId=15, Config=16, Compare k (k>=1) = 23+k; other addresses read 0 and ignore writes.
REQ-011 SHALL increment Count by 1, wrapping 32'hFFFFFFFF->0, on the cycle a prescaler counting 0..COUNT_DIV-1 wraps; COUNT_DIV=1 increments every cycle.
REQ-012 SHALL, on a Count write, load data_i and clear the prescaler; write beats same-cycle increment.
REQ-013 SHALL set timer_int_o[k] the cycle after Count==Compare k with Compare k non-zero; sticky until Compare k is written.
REQ-014 SHALL clear timer_int_o[k] on any write to Compare k; write beats same-cycle match.
REQ-015 SHALL make writable: Status bits 28, 15:8, 1, 0; Cause bits 9:8; all other bits of those registers read 0 or hardware value.
REQ-016 SHALL register Cause[15:10] each cycle from int_i (masked by NUM_HW_INT), with Cause[15] additionally ORed with |timer_int_o.
REQ-017 SHALL on exc_valid_i with Status.EXL=0: EPC=exc_bd_i ? exc_pc_i-4 : exc_pc_i; Cause[31]=exc_bd_i; Cause[6:2]=exc_code_i; Status.EXL=1.
REQ-018 SHALL on exc_valid_i with Status.EXL=1: update only Cause[6:2]; EPC and Cause[31] unchanged.
REQ-019 SHALL on eret_i clear Status.EXL; exc_valid_i beats eret_i in the same cycle.
REQ-020 SHALL give exception/eret priority over a same-cycle mtc0 for EPC, EXL, BD, ExcCode; the mtc0 still updates other writable fields.
REQ-021 SHALL drive int_pending_o = Status.IE & ~Status.EXL & |(Cause[15:8] & Status[15:8]), combinational from registered state.
REQ-022 SHALL make data_o and all register outputs reflect current register state; no write-to-read bypass.

Reset
REQ-023 SHALL on rst: Count=0, prescaler=0, all Compare=0, Status=32'h10000000, Cause=0, EPC=0, Config=32'h00008000, timer_int_o=0.
REQ-024 SHALL give rst priority over every other input, including mid-prescale and pending exception.
REQ-025 SHALL hold prid_o=PRID_VALUE constantly, independent of rst.

Structure
REQ-026 SHALL put CP0 register addresses, reset values, writable-bit masks and ExcCode constants in shared package cp0_pkg.
REQ-027 SHALL implement each compare channel as sub-module cp0_compare_ch (Compare register, match detect, sticky interrupt), generated NUM_TIMERS times.

Verification
REQ-028 SHALL cover: COUNT_DIV=4, Compare0=10 written after reset -> timer_int_o[0] rises when Count reaches 10 (cycle ~41); write Compare0 -> falls next cycle.
REQ-029 SHALL cover: NUM_TIMERS=3, Compare1=5, Compare2=8 -> timer_int_o=3'b010 then 3'b110; Cause[15]=1 throughout.
REQ-030 SHALL cover: exc_valid_i, exc_pc_i=0x100, exc_bd_i=1, code 8 -> EPC=0xFC, Cause=0x80000020, EXL=1; second exception code 12 -> EPC=0xFC, ExcCode=12.
REQ-031 SHALL cover: Status=0x0000_0401, int_i=6'b000001 -> int_pending_o=1 two cycles later; exception -> 0; eret -> 1.
REQ-032 SHALL cover: Count write 0x50 same cycle as increment -> Count=0x50; Compare write same cycle as match -> timer_int_o stays 0.
REQ-033 SHALL cover: rst mid-prescale with timer_int_o=1 -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, reset values, writable-bit
// masks, bit positions and exception codes.
package cp0_pkg;

  // Register addresses (mtc0/mfc0 rd field)
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE0 = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;
  localparam logic [4:0] ADDR_PRID     = 5'd15;
  localparam logic [4:0] ADDR_CONFIG   = 5'd16;

  // Upper bound on compare channels supported by the read/write decode
  localparam int MAX_TIMERS = 4;

  // Reset values
  localparam logic [31:0] STATUS_RESET = 32'h1000_0000;
  localparam logic [31:0] CONFIG_RESET = 32'h0000_8000;

  // Software-writable bits: Status CU0, IM[7:0], EXL, IE; Cause IP[1:0]
  localparam logic [31:0] STATUS_WMASK = 32'h1000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  // Bit positions
  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int CAUSE_BD   = 31;

  // Exception codes carried in Cause[6:2]
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_MOD  = 5'd1,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_CPU  = 5'd11,
    EXC_OV   = 5'd12
  } exc_code_e;

  // Address of compare channel k: channel 0 sits at 11, the rest at 23+k
  function automatic logic [4:0] compare_addr(input int k);
    return (k == 0) ? ADDR_COMPARE0 : 5'(23 + k);
  endfunction

endpackage

// File: rtl/cp0_compare_ch.sv
// One timer compare channel: Compare register, Count match detect and a
// sticky interrupt that only a write to this Compare register clears.
module cp0_compare_ch (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] data,
  input  logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  logic match;

  // A Compare value of zero disables the channel
  assign match = (count == compare) && (compare != '0);

  // Compare register and sticky interrupt; a write wins over a same-cycle match
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order across blocks.
    if (rst) begin
      compare   <= '0;
      timer_int <= 1'b0;
    end else if (we) begin
      compare   <= data;
      timer_int <= 1'b0;
    end else if (match) begin
      timer_int <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_timer_unit.sv
// CP0 slice: Count/Compare timers, Status, Cause, EPC, Config and PRId,
// with exception/eret bookkeeping and interrupt-pending generation.
module cp0_timer_unit
  import cp0_pkg::*;
#(
  parameter int          NUM_HW_INT = 6,
  parameter int          NUM_TIMERS = 1,
  parameter int          COUNT_DIV  = 1,
  parameter logic [31:0] PRID_VALUE = 32'h004C_0102
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [31:0]           data_i,
  input  logic [4:0]            raddr_i,
  output logic [31:0]           data_o,
  input  logic [5:0]            int_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic [31:0]           exc_pc_i,
  input  logic                  exc_bd_i,
  input  logic                  eret_i,
  output logic [31:0]           count_o,
  output logic [31:0]           compare_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic [31:0]           config_o,
  output logic [31:0]           prid_o,
  output logic [NUM_TIMERS-1:0] timer_int_o,
  output logic                  int_pending_o
);

  localparam logic [7:0] PRESC_LAST  = 8'(COUNT_DIV - 1);
  localparam logic [5:0] HW_INT_MASK = 6'((1 << NUM_HW_INT) - 1);

  logic [31:0] count, status, cause, epc;
  logic [31:0] status_d, cause_d, epc_d;
  logic [7:0]  presc;
  logic        tick;
  logic [5:0]  hw_ip;
  logic [31:0] compare_r [MAX_TIMERS];

  logic count_we, status_we, cause_we, epc_we;

  assign count_we  = we_i && (waddr_i == ADDR_COUNT);
  assign status_we = we_i && (waddr_i == ADDR_STATUS);
  assign cause_we  = we_i && (waddr_i == ADDR_CAUSE);
  assign epc_we    = we_i && (waddr_i == ADDR_EPC);

  // ---------------------------------------------------------------------------
  // Compare channels; unused slots read as zero
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < MAX_TIMERS; k++) begin : g_ch
    if (k < NUM_TIMERS) begin : g_live
      cp0_compare_ch u_ch (
        .clk       (clk),
        .rst       (rst),
        .we        (we_i && (waddr_i == compare_addr(k))),
        .data      (data_i),
        .count     (count),
        .compare   (compare_r[k]),
        .timer_int (timer_int_o[k])
      );
    end else begin : g_none
      assign compare_r[k] = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Count and its prescaler
  // ---------------------------------------------------------------------------
  assign tick = (presc == PRESC_LAST);

  // Prescaler wraps at COUNT_DIV-1 and bumps Count; an mtc0 to Count restarts both
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      presc <= '0;
    end else if (count_we) begin
      count <= data_i;
      presc <= '0;
    end else begin
      presc <= tick ? 8'd0 : presc + 8'd1;
      if (tick) count <= count + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Status / Cause / EPC next state
  // ---------------------------------------------------------------------------
  // Live hardware lines; IP7 also carries the OR of all timer interrupts
  always_comb begin
    hw_ip    = int_i & HW_INT_MASK;
    hw_ip[5] = hw_ip[5] | (|timer_int_o);
  end

  // mtc0 first, then exception/eret override the fields they own
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    status_d = status;
    cause_d  = cause;
    epc_d    = epc;

    if (status_we) status_d = (status & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
    if (cause_we)  cause_d  = (cause & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
    if (epc_we)    epc_d    = data_i;

    cause_d[15:10] = hw_ip;

    if (exc_valid_i) begin
      cause_d[6:2] = exc_code_i;
      if (!status[STATUS_EXL]) begin
        epc_d               = exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
        cause_d[CAUSE_BD]   = exc_bd_i;
        status_d[STATUS_EXL] = 1'b1;
      end
    end else if (eret_i) begin
      status_d[STATUS_EXL] = 1'b0;
    end
  end

  // Architectural register update
  always_ff @(posedge clk) begin
    if (rst) begin
      status <= STATUS_RESET;
      cause  <= '0;
      epc    <= '0;
    end else begin
      status <= status_d;
      cause  <= cause_d;
      epc    <= epc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign count_o   = count;
  assign compare_o = compare_r[0];
  assign status_o  = status;
  assign cause_o   = cause;
  assign epc_o     = epc;
  assign config_o  = CONFIG_RESET;
  assign prid_o    = PRID_VALUE;

  assign int_pending_o = status[STATUS_IE] & ~status[STATUS_EXL]
                       & (|(cause[15:8] & status[15:8]));

  // Read mux over current register state
  always_comb begin
    data_o = '0;
    case (raddr_i)
      ADDR_COUNT:    data_o = count;
      ADDR_COMPARE0: data_o = compare_r[0];
      ADDR_STATUS:   data_o = status;
      ADDR_CAUSE:    data_o = cause;
      ADDR_EPC:      data_o = epc;
      ADDR_PRID:     data_o = PRID_VALUE;
      ADDR_CONFIG:   data_o = CONFIG_RESET;
      default: begin
        for (int k = 1; k < MAX_TIMERS; k++) begin
          if (raddr_i == compare_addr(k)) data_o = compare_r[k];
        end
      end
    endcase
  end

endmodule
